shift_left_sequential: RTL and testbench

- Multi-cycle logical left shifter with valid/ready handshakes on both input and output.
- It is the left-direction counterpart of the ALU's right shifters. It is built as a log-stage shifter that resolves one shamt bit per cycle instead of a 32-way mux.
- It sits beside the ALU as an area-reduced shift unit for the multi-cycle datapath.
- It also reports whether any 1 bit was shifted out, for overflow or debug use.

---
 rtl/shift_left_sequential.sv | 105 ++++++++++
 tb/tb_shift_left_sequential.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/shift_left_sequential.sv
// shift_left_sequential: multi-cycle logical left shifter with valid/ready handshakes.
//
// Resolves one shamt bit per clock, MSB-weighted stage first (16, 8, 4, 2, 1 for N=32),
// so latency is a fixed STAGES cycles regardless of the shift amount. Also flags whether
// any 1 bit was pushed out past the MSB.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   operand presented
//   in_ready   block can accept an operand (high only when idle)
//   in         value to shift
//   shamt      shift amount, 0..N-1
//   out_valid  result available
//   out_ready  consumer accepts result
//   out        in << shamt, zero-filled from the LSB
//   lost       1 if any 1 bit was shifted out past the MSB
module shift_left_sequential #(
  parameter int unsigned N      = 32,
  parameter int unsigned STAGES = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      in,
  input  logic [STAGES-1:0] shamt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0]      out,
  output logic              lost
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  localparam logic [STAGES-1:0] LastStage = STAGES'(STAGES - 1);
  localparam logic [N-1:0]      Ones      = '1;

  state_e            state_q;
  logic [N-1:0]      data_q;
  logic [STAGES-1:0] shamt_q;
  logic [STAGES-1:0] cnt_q;
  logic              lost_q;

  // Per-stage datapath: stage k tests shamt bit (STAGES-1-k) with weight 2^(STAGES-1-k).
  logic [STAGES-1:0] bit_idx;
  logic              stage_on;
  int unsigned       weight;
  logic [N-1:0]      shifted;
  logic [N-1:0]      spill;

  always_comb begin
    bit_idx  = LastStage - cnt_q;
    stage_on = shamt_q[bit_idx];
    weight   = 32'd1 << bit_idx;
    shifted  = data_q << weight;
    // Top 'weight' bits are exactly the ones this stage would discard.
    spill    = data_q & ~(Ones >> weight);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      data_q  <= '0;
      shamt_q <= '0;
      cnt_q   <= '0;
      lost_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            data_q  <= in;
            shamt_q <= shamt;
            lost_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= StShift;
          end
        end
        StShift: begin
          if (stage_on) begin
            data_q <= shifted;
            lost_q <= lost_q | (|spill);
          end
          cnt_q <= cnt_q + STAGES'(1);
          if (cnt_q == LastStage) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          // out/lost stay in data_q/lost_q until the next accept overwrites them.
          if (out_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign out       = data_q;
  assign lost      = lost_q;

endmodule

// File: tb/tb_shift_left_sequential.sv
module tb_shift_left_sequential;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in;
  logic [4:0]  shamt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
  logic        lost;

  int n_checks = 0;
  int n_fail   = 0;

  shift_left_sequential #(.N(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (in),
    .shamt     (shamt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .lost      (lost)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for out_valid; returns edges waited.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
  endtask

  // Full operation from IDLE; completes the handshake only when out_ready is high.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [4:0] s,
                        input logic [31:0] exp_out, input logic exp_lost);
    int lat;
    check_eq({tag, "_rdy_idle"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in       = a;
    shamt    = s;
    step();  // accept edge
    in_valid = 1'b0;
    in       = 32'hA5A5_A5A5;  // must not matter after accept
    shamt    = 5'd7;
    check_eq({tag, "_rdy_busy"}, 32'(in_ready), 32'd0);
    check_eq({tag, "_vld_busy"}, 32'(out_valid), 32'd0);
    wait_valid(lat);
    check_eq({tag, "_latency"}, lat, 32'd5);
    check_eq({tag, "_out"}, out, exp_out);
    check_eq({tag, "_lost"}, 32'(lost), 32'(exp_lost));
    if (out_ready) begin
      step();
      check_eq({tag, "_vld_drop"}, 32'(out_valid), 32'd0);
      check_eq({tag, "_rdy_back"}, 32'(in_ready), 32'd1);
      check_eq({tag, "_out_keep"}, out, exp_out);
    end
  endtask

  initial begin
    int lat;
    int acc_n;
    int acc_cyc[2];

    rst       = 1'b1;
    in_valid  = 1'b0;
    in        = '0;
    shamt     = '0;
    out_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out", out, 32'd0);
    check_eq("rst_lost", 32'(lost), 32'd0);

    run_op("max_shift", 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0);
    run_op("lost_bits", 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFF0, 1'b1);
    run_op("zero_shift", 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1'b0);
    run_op("mid_shift", 32'h0F0F_0001, 5'd5, 32'hE1E0_0020, 1'b1);

    // Backpressure: result held while a competing operand waits.
    out_ready = 1'b0;
    run_op("bp", 32'h1234_5678, 5'd8, 32'h3456_7800, 1'b1);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in       = 32'h0000_0003;
      shamt    = 5'd1;
      step();
      check_eq("bp_hold_valid", 32'(out_valid), 32'd1);
      check_eq("bp_hold_rdy", 32'(in_ready), 32'd0);
      check_eq("bp_hold_out", out, 32'h3456_7800);
      check_eq("bp_hold_lost", 32'(lost), 32'd1);
    end
    out_ready = 1'b1;
    step();  // handshake edge; no accept possible here
    check_eq("bp_hs_valid", 32'(out_valid), 32'd0);
    check_eq("bp_hs_rdy", 32'(in_ready), 32'd1);
    check_eq("bp_hs_out", out, 32'h3456_7800);
    step();  // second operand accepted now
    in_valid = 1'b0;
    check_eq("bp_2nd_rdy", 32'(in_ready), 32'd0);
    wait_valid(lat);
    check_eq("bp_2nd_lat", lat, 32'd5);
    check_eq("bp_2nd_out", out, 32'h0000_0006);
    check_eq("bp_2nd_lost", 32'(lost), 32'd0);
    step();

    // Reset after the 2nd SHIFT edge discards the operation.
    in_valid = 1'b1;
    in       = 32'hFFFF_FFFF;
    shamt    = 5'd31;
    step();  // accept
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("mid_rst_rdy", 32'(in_ready), 32'd1);
    check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
    check_eq("mid_rst_out", out, 32'd0);
    check_eq("mid_rst_lost", 32'(lost), 32'd0);
    run_op("after_rst", 32'h0000_00FF, 5'd28, 32'hF000_0000, 1'b1);

    // Back-to-back with in_valid and out_ready held high: accepts 7 cycles apart.
    in_valid = 1'b1;
    in       = 32'h0000_0001;
    shamt    = 5'd3;
    acc_n    = 0;
    for (int c = 0; c < 40 && acc_n < 2; c++) begin
      if (in_valid && in_ready) begin
        acc_cyc[acc_n] = c;
        acc_n++;
      end
      step();
    end
    in_valid = 1'b0;
    check_eq("b2b_count", acc_n, 32'd2);
    if (acc_n == 2) check_eq("b2b_gap", acc_cyc[1] - acc_cyc[0], 32'd7);
    wait_valid(lat);
    check_eq("b2b_lat", lat, 32'd5);
    check_eq("b2b_out", out, 32'h0000_0008);
    check_eq("b2b_lost", 32'(lost), 32'd0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
